// File: rtl/adxl362_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : adxl362_fifo_ctrl_if
// Desc   : Port bundle between the FIFO controller and the 512x16 sample FIFO.
// Rev    : 1.0  initial release
// ============================================================================
interface adxl362_fifo_ctrl_if;
   logic [15:0] fifo_data_write;
   logic        fifo_write;
   logic        fifo_read;
   logic        fifo_flush;
   logic [15:0] fifo_data_read;
   logic        fifo_full;
   logic        fifo_empty;

   modport master (
      output fifo_data_write, fifo_write, fifo_read, fifo_flush,
      input  fifo_data_read, fifo_full, fifo_empty
   );

   modport slave (
      input  fifo_data_write, fifo_write, fifo_read, fifo_flush,
      output fifo_data_read, fifo_full, fifo_empty
   );
endinterface
`default_nettype wire

// File: rtl/adxl362_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : adxl362_fifo_ctrl
// Desc   : ADXL362 FIFO sequencer: set packing, mode policy, SPI read sharing.
// Rev    : 1.0  initial release
// ============================================================================
module adxl362_fifo_ctrl #(
   parameter int DEPTH     = 512,
   parameter int CNT_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           fifo_mode,
   input  logic                 fifo_temp,
   input  logic [8:0]           fifo_samples,
   input  logic                 flush_req,
   input  logic                 trigger,
   input  logic                 sample_valid,
   input  logic [11:0]          x_data,
   input  logic [11:0]          y_data,
   input  logic [11:0]          z_data,
   input  logic [11:0]          t_data,
   input  logic                 spi_rd_req,
   output logic [15:0]          spi_rd_data,
   output logic                 spi_rd_valid,
   adxl362_fifo_ctrl_if.master  fifo,
   output logic [CNT_WIDTH-1:0] entries,
   output logic                 watermark,
   output logic                 overrun
);
   localparam logic [1:0]           c_MODE_OFF    = 2'b00;
   localparam logic [1:0]           c_MODE_STREAM = 2'b10;
   localparam logic [1:0]           c_MODE_TRIG   = 2'b11;
   localparam logic [CNT_WIDTH-1:0] c_DEPTH_CNT   = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH:0]   c_DEPTH_EXT   = (CNT_WIDTH+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_HI   = 3'd1,
      S_WR_LO   = 3'd2,
      S_DISCARD = 3'd3,
      S_FLUSH   = 3'd4
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [11:0]          r_x, r_y, r_z, r_t;
   logic                 r_temp;
   logic [1:0]           r_idx, r_disc;
   logic                 r_pending, r_triggered;
   logic [1:0]           r_mode_prev;
   logic [CNT_WIDTH-1:0] r_entries;
   logic                 r_watermark, r_overrun, r_spi_valid;
   logic [15:0]          r_spi_data;
   logic                 w_flush, w_over, w_keep_new, w_want_rd;
   logic                 w_start, w_drop, w_svc, w_write, w_read;
   logic [2:0]           w_n;
   logic [1:0]           w_last_idx;
   logic [CNT_WIDTH:0]   w_need;
   logic [11:0]          w_sel;

   assign w_flush    = flush_req || (fifo_mode == c_MODE_OFF && r_mode_prev != c_MODE_OFF);
   assign w_n        = fifo_temp ? 3'd4 : 3'd3;
   assign w_need     = {1'b0, r_entries} + (CNT_WIDTH+1)'(w_n);
   assign w_over     = (w_need > c_DEPTH_EXT) || fifo.fifo_full;
   // Stream mode, and triggered mode before its trigger, keep the newest data.
   assign w_keep_new = (fifo_mode == c_MODE_STREAM) || (fifo_mode == c_MODE_TRIG && !r_triggered);
   assign w_last_idx = r_temp ? 2'd3 : 2'd2;
   assign w_want_rd  = r_pending || spi_rd_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_drop      = 1'b0;
      w_svc       = 1'b0;
      w_write     = 1'b0;
      w_read      = 1'b0;
      if (w_flush) begin
         w_state_nxt = S_FLUSH;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sample_valid && fifo_mode != c_MODE_OFF) begin
                  if (!w_over) begin
                     w_start     = 1'b1;
                     w_state_nxt = S_WR_HI;
                  end else if (w_keep_new) begin
                     w_start     = 1'b1;
                     w_state_nxt = S_DISCARD;
                  end else begin
                     w_drop = 1'b1;
                  end
               end
            end
            S_WR_HI: begin
               w_write     = 1'b1;
               w_state_nxt = S_WR_LO;
            end
            S_WR_LO:   w_state_nxt = (r_idx == w_last_idx) ? S_IDLE : S_WR_HI;
            S_DISCARD: begin
               w_read = 1'b1;
               if (r_disc == 2'd0) w_state_nxt = S_WR_HI;
            end
            S_FLUSH:   w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
         endcase
         if (sample_valid && fifo_mode != c_MODE_OFF &&
             r_state != S_IDLE && r_state != S_FLUSH)
            w_drop = 1'b1;
         if (w_want_rd && r_state != S_DISCARD && r_state != S_FLUSH) begin
            w_svc = 1'b1;
            if (!fifo.fifo_empty) w_read = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel = r_x;
      case (r_idx)
         2'd1:    w_sel = r_y;
         2'd2:    w_sel = r_z;
         2'd3:    w_sel = r_t;
         default: w_sel = r_x;
      endcase
   end

   // Entry index doubles as the tag: 00 X, 01 Y, 10 Z, 11 T.
   assign fifo.fifo_data_write = {r_idx, {2{w_sel[11]}}, w_sel};
   assign fifo.fifo_write      = w_write;
   assign fifo.fifo_read       = w_read;
   assign fifo.fifo_flush      = (r_state == S_FLUSH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_t         <= '0;
         r_temp      <= 1'b0;
         r_idx       <= '0;
         r_disc      <= '0;
         r_pending   <= 1'b0;
         r_triggered <= 1'b0;
         r_mode_prev <= c_MODE_OFF;
         r_entries   <= '0;
         r_watermark <= 1'b0;
         r_overrun   <= 1'b0;
         r_spi_valid <= 1'b0;
         r_spi_data  <= '0;
      end else begin
         r_mode_prev <= fifo_mode;
         r_spi_valid <= w_svc;
         r_watermark <= (fifo_samples != 9'd0) && (r_entries >= CNT_WIDTH'(fifo_samples));
         if (w_svc) r_spi_data <= fifo.fifo_empty ? 16'h0000 : fifo.fifo_data_read;
         if (w_start) begin
            r_x    <= x_data;
            r_y    <= y_data;
            r_z    <= z_data;
            r_t    <= t_data;
            r_temp <= fifo_temp;
            r_idx  <= 2'd0;
            r_disc <= 2'(w_n - 3'd1);
         end else if (r_state == S_WR_LO && w_state_nxt == S_WR_HI) begin
            r_idx <= r_idx + 2'd1;
         end
         if (r_state == S_DISCARD) r_disc <= r_disc - 2'd1;
         if (w_flush) begin
            r_entries   <= '0;
            r_overrun   <= 1'b0;
            r_triggered <= 1'b0;
            r_pending   <= 1'b0;
         end else begin
            case ({w_write, w_read})
               2'b10:   if (r_entries != c_DEPTH_CNT) r_entries <= r_entries + 1'b1;
               2'b01:   if (r_entries != '0)          r_entries <= r_entries - 1'b1;
               default: r_entries <= r_entries;
            endcase
            if (w_drop) r_overrun <= 1'b1;
            if (fifo_mode != c_MODE_TRIG) r_triggered <= 1'b0;
            else if (trigger)             r_triggered <= 1'b1;
            if (w_svc)           r_pending <= 1'b0;
            else if (spi_rd_req) r_pending <= 1'b1;
         end
      end
   end

   assign entries      = r_entries;
   assign watermark    = r_watermark;
   assign overrun      = r_overrun;
   assign spi_rd_data  = r_spi_data;
   assign spi_rd_valid = r_spi_valid;
endmodule
`default_nettype wire

// File: tb/tb_adxl362_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_adxl362_fifo_ctrl
// Desc   : Directed-vector bench for adxl362_fifo_ctrl with a behavioural FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adxl362_fifo_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  fifo_mode;
   logic        fifo_temp;
   logic [8:0]  fifo_samples;
   logic        flush_req, trigger, sample_valid, spi_rd_req;
   logic [11:0] x_data, y_data, z_data, t_data;
   logic [15:0] spi_rd_data;
   logic        spi_rd_valid;
   logic [9:0]  entries;
   logic        watermark, overrun;

   always #5 clk = ~clk;

   adxl362_fifo_ctrl_if fif ();

   adxl362_fifo_ctrl #(.DEPTH(512), .CNT_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .fifo_mode(fifo_mode), .fifo_temp(fifo_temp),
      .fifo_samples(fifo_samples), .flush_req(flush_req), .trigger(trigger),
      .sample_valid(sample_valid), .x_data(x_data), .y_data(y_data),
      .z_data(z_data), .t_data(t_data), .spi_rd_req(spi_rd_req),
      .spi_rd_data(spi_rd_data), .spi_rd_valid(spi_rd_valid), .fifo(fif.master),
      .entries(entries), .watermark(watermark), .overrun(overrun)
   );

   // Behavioural 512x16 FIFO with a combinational head.
   logic [15:0] mem [512];
   logic [8:0]  rp, wp;
   logic [9:0]  cnt;
   logic        m_rd, m_wr;
   assign m_rd = fif.fifo_read && (cnt != 10'd0);
   assign m_wr = fif.fifo_write && ((cnt != 10'd512) || m_rd);
   assign fif.fifo_data_read = mem[rp];
   assign fif.fifo_empty     = (cnt == 10'd0);
   assign fif.fifo_full      = (cnt == 10'd512);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rp <= '0; wp <= '0; cnt <= '0;
      end else if (fif.fifo_flush) begin
         rp <= '0; wp <= '0; cnt <= '0;
      end else begin
         if (m_wr) begin
            mem[wp] <= fif.fifo_data_write;
            wp      <= wp + 9'd1;
         end
         if (m_rd) rp <= rp + 9'd1;
         cnt <= cnt + {9'd0, m_wr} - {9'd0, m_rd};
      end
   end

   // Event monitor, sampled mid-cycle.
   int          cyc = 0;
   int          sv_cyc = 0, n_flush = 0, n_valid = 0, b2b = 0;
   logic        prev_wr = 1'b0;
   logic [15:0] wr_log[$];
   int          wr_cyc[$];
   int          rd_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fif.fifo_write) begin
         wr_log.push_back(fif.fifo_data_write);
         wr_cyc.push_back(cyc);
         if (prev_wr) b2b = b2b + 1;
      end
      prev_wr = fif.fifo_write;
      if (fif.fifo_read)  rd_cyc.push_back(cyc);
      if (fif.fifo_flush) n_flush = n_flush + 1;
      if (spi_rd_valid)   n_valid = n_valid + 1;
      if (sample_valid)   sv_cyc = cyc;
   end

   int n_vec = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_logs();
      wr_log.delete();
      wr_cyc.delete();
      rd_cyc.delete();
   endtask

   task automatic send_set(input logic [11:0] x, input logic [11:0] y,
                           input logic [11:0] z, input logic [11:0] t, input logic tmp);
      x_data = x; y_data = y; z_data = z; t_data = t;
      fifo_temp    = tmp;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic spi_read();
      spi_rd_req = 1'b1;
      tick();
      spi_rd_req = 1'b0;
   endtask

   task automatic fill(input int nsets, input logic tmp);
      for (int i = 0; i < nsets; i++) begin
         send_set(12'(i), 12'h111, 12'h222, 12'h333, tmp);
         repeat (tmp ? 8 : 6) tick();
      end
   endtask

   typedef struct packed {
      logic [11:0] x, y, z, t;
      logic        temp;
      logic [15:0] e0, e1, e2, e3;
   } vec_t;

   vec_t        vt[4];
   logic [15:0] ew[4];
   int          n, base_flush, base_valid;

   initial begin
      vt[0] = '{x:12'h800, y:12'h123, z:12'h7FF, t:12'h000, temp:1'b0,
                e0:16'h3800, e1:16'h4123, e2:16'h87FF, e3:16'h0000};
      vt[1] = '{x:12'hFFF, y:12'h000, z:12'hA5A, t:12'hF00, temp:1'b1,
                e0:16'h3FFF, e1:16'h4000, e2:16'hBA5A, e3:16'hFF00};
      vt[2] = '{x:12'h001, y:12'h800, z:12'h000, t:12'h7FF, temp:1'b1,
                e0:16'h0001, e1:16'h7800, e2:16'h8000, e3:16'hC7FF};
      vt[3] = '{x:12'h7FF, y:12'hFFE, z:12'h400, t:12'h555, temp:1'b0,
                e0:16'h07FF, e1:16'h7FFE, e2:16'h8400, e3:16'h0000};

      rst = 1'b0; fifo_mode = 2'b00; fifo_temp = 1'b0; fifo_samples = 9'd0;
      flush_req = 1'b0; trigger = 1'b0; sample_valid = 1'b0; spi_rd_req = 1'b0;
      x_data = '0; y_data = '0; z_data = '0; t_data = '0;
      repeat (3) tick();
      chk("rst_entries", entries, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_watermark", watermark, 0);
      chk("rst_spi_valid", spi_rd_valid, 0);
      chk("rst_spi_data", spi_rd_data, 0);
      chk("rst_fifo_write", fif.fifo_write, 0);
      chk("rst_fifo_flush", fif.fifo_flush, 0);
      chk("rst_wdata", fif.fifo_data_write, 0);
      rst = 1'b1;
      tick();

      // Packing vectors in oldest-saved mode.
      fifo_mode = 2'b01;
      tick();
      for (int i = 0; i < 4; i++) begin
         n = vt[i].temp ? 4 : 3;
         ew[0] = vt[i].e0; ew[1] = vt[i].e1; ew[2] = vt[i].e2; ew[3] = vt[i].e3;
         do_flush();
         chk("vec_flush_entries", entries, 0);
         clr_logs();
         send_set(vt[i].x, vt[i].y, vt[i].z, vt[i].t, vt[i].temp);
         repeat (2 * n + 1) tick();
         chk("vec_wr_count", wr_log.size(), n);
         for (int k = 0; k < n; k++) begin
            if (k < wr_log.size()) begin
               chk("vec_wr_data", wr_log[k], ew[k]);
               chk("vec_wr_cycle", wr_cyc[k] - sv_cyc, 2 * k + 1);
            end
         end
         chk("vec_entries", entries, n);
         spi_read();
         chk("vec_spi_valid", spi_rd_valid, 1);
         chk("vec_spi_data", spi_rd_data, ew[0]);
         chk("vec_entries_after_rd", entries, n - 1);
      end

      // sample_valid while a set is being written is dropped.
      do_flush();
      clr_logs();
      send_set(12'h010, 12'h020, 12'h030, 12'h000, 1'b0);
      send_set(12'h0AA, 12'h0BB, 12'h0CC, 12'h000, 1'b0);
      repeat (8) tick();
      chk("busy_wr_count", wr_log.size(), 3);
      chk("busy_overrun", overrun, 1);
      chk("busy_entries", entries, 3);

      // Watermark at 6 entries, then one SPI read drops it.
      do_flush();
      fifo_samples = 9'd6;
      send_set(12'h001, 12'h002, 12'h003, 12'h000, 1'b0);
      repeat (6) tick();
      send_set(12'h004, 12'h005, 12'h006, 12'h000, 1'b0);
      repeat (5) tick();
      chk("wm_entries6", entries, 6);
      chk("wm_not_yet", watermark, 0);
      tick();
      chk("wm_set", watermark, 1);
      spi_read();
      chk("wm_rd_entries", entries, 5);
      tick();
      chk("wm_clear", watermark, 0);
      fifo_samples = 9'd0;

      // Oldest-saved: full FIFO drops the new set.
      do_flush();
      chk("full_overrun_pre", overrun, 0);
      fill(170, 1'b0);
      chk("full_entries510", entries, 510);
      chk("full_wm_disabled", watermark, 0);
      clr_logs();
      send_set(12'h123, 12'h456, 12'h789, 12'h000, 1'b0);
      repeat (8) tick();
      chk("full_no_write", wr_log.size(), 0);
      chk("full_overrun", overrun, 1);
      chk("full_entries_kept", entries, 510);

      // Switching to mode 00 flushes; samples are then ignored.
      base_flush = n_flush;
      fifo_mode = 2'b00;
      repeat (3) tick();
      chk("off_flush_pulse", n_flush - base_flush, 1);
      chk("off_entries", entries, 0);
      chk("off_overrun", overrun, 0);
      clr_logs();
      send_set(12'h111, 12'h222, 12'h333, 12'h000, 1'b0);
      repeat (8) tick();
      chk("off_ignored", wr_log.size(), 0);
      chk("off_overrun_kept", overrun, 0);

      // Stream mode at 512 entries: 4 pops then 4 writes.
      fifo_mode = 2'b10;
      tick();
      fill(128, 1'b1);
      chk("stream_entries512", entries, 512);
      clr_logs();
      send_set(12'hABC, 12'h0DE, 12'h0F0, 12'h00F, 1'b1);
      repeat (13) tick();
      chk("stream_rd_count", rd_cyc.size(), 4);
      if (rd_cyc.size() >= 4) begin
         chk("stream_rd_start", rd_cyc[0] - sv_cyc, 1);
         chk("stream_rd_consec", rd_cyc[3] - rd_cyc[0], 3);
      end
      chk("stream_wr_count", wr_log.size(), 4);
      if (wr_log.size() >= 1) begin
         chk("stream_wr_start", wr_cyc[0] - sv_cyc, 5);
         chk("stream_wr_data", wr_log[0], 16'h3ABC);
      end
      chk("stream_entries", entries, 512);
      chk("stream_overrun", overrun, 0);
      chk("stream_head", fif.fifo_data_read, 16'h0001);

      // Triggered mode before trigger discards; merged SPI reads during discard.
      fifo_mode = 2'b11;
      tick();
      clr_logs();
      base_valid = n_valid;
      send_set(12'h321, 12'h654, 12'h987, 12'h0AB, 1'b1);
      spi_rd_req = 1'b1;
      tick();
      tick();
      spi_rd_req = 1'b0;
      repeat (12) tick();
      chk("trig_rd_count", rd_cyc.size(), 5);
      chk("trig_wr_count", wr_log.size(), 4);
      chk("trig_merged_valid", n_valid - base_valid, 1);
      chk("trig_spi_data", spi_rd_data, 16'h0002);
      chk("trig_entries", entries, 511);
      chk("trig_overrun_pre", overrun, 0);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      clr_logs();
      send_set(12'h222, 12'h333, 12'h444, 12'h555, 1'b1);
      repeat (10) tick();
      chk("trig_drop_wr", wr_log.size(), 0);
      chk("trig_drop_rd", rd_cyc.size(), 0);
      chk("trig_overrun", overrun, 1);
      chk("trig_entries_kept", entries, 511);
      base_flush = n_flush;
      do_flush();
      chk("flush_pulse", n_flush - base_flush, 1);
      chk("flush_entries", entries, 0);
      chk("flush_overrun", overrun, 0);

      // SPI read on empty FIFO.
      clr_logs();
      spi_read();
      chk("empty_valid", spi_rd_valid, 1);
      chk("empty_data", spi_rd_data, 16'h0000);
      chk("empty_no_read", rd_cyc.size(), 0);
      tick();
      chk("empty_valid_pulse", spi_rd_valid, 0);

      // SPI read alongside the second write of a set.
      fifo_mode = 2'b01;
      tick();
      send_set(12'h0C3, 12'h0D4, 12'h0E5, 12'h000, 1'b0);
      tick();
      tick();
      spi_read();
      chk("mid_valid", spi_rd_valid, 1);
      chk("mid_data", spi_rd_data, 16'h00C3);
      chk("mid_entries_same", entries, 1);
      repeat (6) tick();
      chk("mid_entries_end", entries, 2);

      // Asynchronous reset in the middle of a set.
      do_flush();
      clr_logs();
      send_set(12'h0AB, 12'h0CD, 12'h0EF, 12'h000, 1'b0);
      tick();
      rst = 1'b0;
      #2;
      chk("arst_write", fif.fifo_write, 0);
      chk("arst_entries", entries, 0);
      repeat (2) tick();
      rst = 1'b1;
      repeat (8) tick();
      chk("arst_no_resume", wr_log.size(), 1);
      chk("arst_entries_after", entries, 0);

      chk("no_b2b_write", b2b, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
